// File: rtl/bus_pkg.sv
// Shared definitions for the bus memory and its arbiter.
// Widths match the 256x10 single-port bus memory.
package bus_pkg;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 10;
   localparam int MEM_DEPTH = 256;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;
endpackage

// File: rtl/bus_mem_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed priority (index 0 highest).
// Zero latency; winner is one-hot, or all zero when nothing requests.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   input  logic               fixed_pri,
   output logic [NUM_REQ-1:0] winner
);
   logic found;
   int   start;
   int   idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      start  = fixed_pri ? 0 : int'(ptr);
      idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (start + i) % NUM_REQ;
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/my_bus_ctrl.sv
// Single-port bus memory: synchronous write, registered read with 1-cycle latency.
// Read data is 0 in any cycle following one without bus_rd_en.
module my_bus_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 10,
   parameter int MEM_DEPTH = bus_pkg::MEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_wr_en,
   input  logic [ADDR_W-1:0] bus_wr_addr,
   input  logic [DATA_W-1:0] bus_wr_data,
   input  logic              bus_rd_en,
   input  logic [ADDR_W-1:0] bus_rd_addr,
   output logic [DATA_W-1:0] bus_rd_data
);
   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (bus_wr_en) mem[bus_wr_addr] <= bus_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus_rd_data <= '0;
      else        bus_rd_data <= bus_rd_en ? mem[bus_rd_addr] : '0;
   end
endmodule

// File: rtl/bus_mem_arbiter.sv
// Shares the bus memory between NUM_REQ requesters: grant+command 1 cycle after req sampled,
// read data 1 cycle later; one transaction per 2 cycles, requesters hold req until gnt.
module bus_mem_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic                      fixed_pri,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic                      bus_wr_en,
   output logic [ADDR_W-1:0]         bus_wr_addr,
   output logic [DATA_W-1:0]         bus_wr_data,
   output logic                      bus_rd_en,
   output logic [ADDR_W-1:0]         bus_rd_addr,
   input  logic [DATA_W-1:0]         bus_rd_data
);
   import bus_pkg::state_t;
   import bus_pkg::ST_IDLE;
   import bus_pkg::ST_ISSUE;

   localparam int               PTR_W    = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   state_t               state;
   logic [PTR_W-1:0]     ptr;
   logic [NUM_REQ-1:0]   winner;
   logic [NUM_REQ-1:0]   rd_pend;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic                 sel_we;
   logic [PTR_W-1:0]     sel_idx;
   logic [PTR_W-1:0]     ptr_next;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req       (req),
      .ptr       (ptr),
      .fixed_pri (fixed_pri),
      .winner    (winner)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_we    = req_we[i];
            sel_idx   = PTR_W'(i);
         end
      end
      ptr_next = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
   end

   // rvalid is only ever high in the IDLE cycle after a read ISSUE, so rdata needs no extra register.
   assign rdata = (|rvalid) ? bus_rd_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         gnt         <= '0;
         rvalid      <= '0;
         rd_pend     <= '0;
         busy        <= 1'b0;
         bus_wr_en   <= 1'b0;
         bus_wr_addr <= '0;
         bus_wr_data <= '0;
         bus_rd_en   <= 1'b0;
         bus_rd_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rvalid <= '0;
               if (|req) begin
                  state       <= ST_ISSUE;
                  gnt         <= winner;
                  busy        <= 1'b1;
                  bus_wr_en   <= sel_we;
                  bus_wr_addr <= sel_we ? sel_addr : '0;
                  bus_wr_data <= sel_we ? sel_wdata : '0;
                  bus_rd_en   <= !sel_we;
                  bus_rd_addr <= sel_we ? '0 : sel_addr;
                  rd_pend     <= sel_we ? '0 : winner;
                  if (!fixed_pri) ptr <= ptr_next;
               end
            end
            ST_ISSUE: begin
               state       <= ST_IDLE;
               gnt         <= '0;
               busy        <= 1'b0;
               bus_wr_en   <= 1'b0;
               bus_wr_addr <= '0;
               bus_wr_data <= '0;
               bus_rd_en   <= 1'b0;
               bus_rd_addr <= '0;
               rvalid      <= rd_pend;
               rd_pend     <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/bus_mem_arbiter.md
Name: bus_mem_arbiter

Overview:
- Round-robin arbiter that shares the single-port 256x10 bus memory (my_bus_ctrl) between NUM_REQ requesters.
- Sits between the requesters and my_bus_ctrl.
- Owns all bus_wr_*/bus_rd_* command lines.
- Returns read data to the winning requester with a one-cycle valid pulse.
- Serialises accesses; at most one command is presented to the memory per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, memory address width.
- DATA_W, 10, memory data width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-requester access request; held until gnt seen.
- req_we  input  NUM_REQ  per-requester: 1=write, 0=read.
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  flattened write data.
- fixed_pri  input  1  1=fixed priority (index 0 highest), 0=round-robin.
- gnt  output  NUM_REQ  one-hot one-cycle grant pulse.
- rvalid  output  NUM_REQ  one-hot read-data-valid pulse.
- rdata  output  DATA_W  read data; equals bus_rd_data while any rvalid is high, else 0.
- busy  output  1  high while in ISSUE state.
- bus_wr_en  output  1  to memory.
- bus_wr_addr  output  ADDR_W  to memory.
- bus_wr_data  output  DATA_W  to memory.
- bus_rd_en  output  1  to memory.
- bus_rd_addr  output  ADDR_W  to memory.
- bus_rd_data  input  DATA_W  from memory; registered, 1-cycle latency, 0 when rd_en low.

Behaviour:
- Reset (async):
  - State=IDLE; all outputs 0.
  - RR pointer=0; no read pending.
  - Reset mid-transaction aborts it: no gnt and no rvalid after reset release.
  - A write already registered on the bus at the reset edge is not guaranteed.
- FSM:
  - IDLE: if |req, pick winner w; register command fields, gnt, and pending-read flag; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: always returns to IDLE next cycle.
- During ISSUE, all registered outputs:
  - gnt[w]=1; busy=1.
  - Write: bus_wr_en=1, bus_wr_addr/bus_wr_data = requester w fields captured in IDLE.
  - Read: bus_rd_en=1, bus_rd_addr = captured address.
  - Non-selected command lines are 0.
- Outside ISSUE: bus_wr_en=bus_rd_en=0; addr/data outputs 0.
- Read return: rvalid[w]=1 in the cycle after ISSUE (memory output is valid then); rdata=bus_rd_data.
- Latency:
  - req sampled high at edge E.
  - gnt/command in cycle E..E+1.
  - rvalid/rdata in E+1..E+2.
- Throughput: one transaction per 2 cycles.
- Requester contract: keep req and fields stable until it sees gnt; deassert or present the next request at the edge ending the gnt cycle. The arbiter never samples req during ISSUE, so no double grant.
- Arbitration:
  - Round-robin: search starts at ptr; first requester with req=1 wins.
  - After grant, ptr = w+1 mod NUM_REQ.
  - Fixed priority: lowest index wins; ptr not updated.
  - fixed_pri is sampled only in IDLE.
- Ordering: a read issued after a write to the same address, from any requester, returns the new data. The write commits at the end of its ISSUE cycle; the next command issues no earlier than 2 cycles later.
- rvalid overlapping IDLE: a new decision in that same cycle is allowed. The next ISSUE cannot collide with the rvalid cycle.
- No req: stays in IDLE; all outputs 0.

Decomposition:
- Shared package bus_pkg: ADDR_W=8, DATA_W=10, MEM_DEPTH=256, state encoding (ST_IDLE=1'b0, ST_ISSUE=1'b1).
- Sub-module rr_pick: combinational, inputs req and ptr, output one-hot winner, supports fixed_pri.
- FSM, command registers and read-return logic live in bus_mem_arbiter.
- Bench instantiates bus_mem_arbiter together with my_bus_ctrl.

Test Plan:
1. Reset, then req0 write addr 0x10 data 0x2AB; next transaction req0 read 0x10 -> gnt[0] pulses; rvalid[0]=1 exactly 1 cycle after the read gnt; rdata=0x2AB; rdata=0 elsewhere.
2. All 4 reqs held, reads to 0x00..0x03, round-robin -> gnt order 0,1,2,3,0; gnt pulses every 2nd cycle; never two gnt bits high.
3. fixed_pri=1, req0 and req2 pending continuously -> req0 wins every arbitration; switch to fixed_pri=0 -> req2 granted next.
4. Req1 writes 0x3FF to 0xFF while req2 reads 0xFF in the following arbitration -> req2 rdata=0x3FF (write-then-read ordering, address wrap edge).
5. rst_n low during ISSUE of a read -> gnt, bus_rd_en, rvalid all 0 asynchronously; after release, no stale rvalid; first grant goes to lowest active index (ptr=0).
6. Idle bus (req=0) for 20 cycles -> all outputs 0, busy=0; single req3 read of 0x80 after preloaded write 0x155 -> rvalid[3] only, rdata=0x155.
